// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sequencing NREQ requesters onto one APB master port
// Optional access timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ack,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    output logic               pwrite,
    output logic               psel,
    output logic               penable,
    input  logic               pready,
    input  logic [DW-1:0]      prdata
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   last;
    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [NREQ-1:0] gnt_mask;
    logic [IW:0]     idle_pick;
    logic [IW:0]     b2b_pick;
    logic [IW:0]     pick;
    logic [IW-1:0]   pick_idx;
    logic            tmo_hit;
    logic            xfer_done;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        logic [IW-1:0] r;
        if (int'(i) == NREQ - 1) r = '0;
        else                     r = i + 1'b1;
        return r;
    endfunction

    // Returns {found, index}; the candidate closest to start (wrapping) wins.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] cand,
                                            input logic [IW-1:0]   start);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(start) + k) % NREQ;
            if (cand[j]) res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*DW +: DW];
        end
    end

    assign gnt_mask  = NREQ'(1) << gnt;
    // In IDLE the requester being acked this cycle may still hold valid; do not re-grant it.
    assign idle_pick = rr_pick(req_valid & ~req_ack, wrap_inc(last));
    assign b2b_pick  = rr_pick(req_valid & ~gnt_mask, wrap_inc(gnt));
    assign pick      = (state == IDLE) ? idle_pick : b2b_pick;
    assign pick_idx  = pick[IW-1:0];
    assign xfer_done = (state == ACCESS) && (pready || tmo_hit);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            last      <= IW'(NREQ - 1);
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            req_ack   <= '0;
            rsp_rdata <= '0;
        end else begin
            req_ack <= '0;
            case (state)
                IDLE: begin
                    if (pick[IW]) begin
                        gnt     <= pick_idx;
                        paddr   <= addr_arr[pick_idx];
                        pwdata  <= wdata_arr[pick_idx];
                        pwrite  <= req_write[pick_idx];
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (xfer_done) begin
                        req_ack   <= gnt_mask;
                        rsp_rdata <= pready ? prdata : '0;
                        last      <= gnt;
                        penable   <= 1'b0;
                        // Chain straight into the next SETUP so psel never drops between grants.
                        if (pick[IW]) begin
                            gnt    <= pick_idx;
                            paddr  <= addr_arr[pick_idx];
                            pwdata <= wdata_arr[pick_idx];
                            pwrite <= req_write[pick_idx];
                            state  <= SETUP;
                        end else begin
                            psel  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

    logic [TW-1:0] tcnt;

    // Fires on the TIMEOUT-th consecutive not-ready ACCESS cycle.
    assign tmo_hit = (state == ACCESS) && !pready && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == SETUP) begin
                tcnt <= '0;
            end else if (state == ACCESS && !pready) begin
                tcnt <= tcnt + 1'b1;
            end
            if (xfer_done) begin
                rsp_err <= tmo_hit;
            end
        end
    end
`else
    // ACCESS waits for pready indefinitely.
    assign tmo_hit = (TIMEOUT < 0);
    assign rsp_err = 1'b0;
`endif

endmodule
